// File: rtl/explosion_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// explosion_pkg : shared types, screen defaults and cross-tile test
// Rev 1.0
// ------------------------------------------------------------------
package explosion_pkg;

    typedef enum logic [0:0] {
        CH_IDLE   = 1'b0,
        CH_ACTIVE = 1'b1
    } ch_state_e;

    localparam int DEF_TILE    = 16;
    localparam int TILE_SHIFT  = $clog2(DEF_TILE);
    localparam int DEF_X_TILES = 40;
    localparam int DEF_Y_TILES = 30;

    // Deltas are taken in full signed integers so an arm near tile 0 never
    // wraps around to the far edge of the screen.
    function automatic logic tile_in_cross(
        input logic [9:0] tx,
        input logic [9:0] ty,
        input logic [9:0] cx,
        input logic [9:0] cy,
        input int         radius,
        input int         x_tiles,
        input int         y_tiles
    );
        int   dx;
        int   dy;
        logic on_screen;
        logic in_row;
        logic in_col;
        dx        = int'(tx) - int'(cx);
        dy        = int'(ty) - int'(cy);
        on_screen = (int'(tx) < x_tiles) && (int'(ty) < y_tiles);
        in_row    = (ty == cy) && (dx <= radius) && (dx >= -radius);
        in_col    = (tx == cx) && (dy <= radius) && (dy >= -radius);
        return on_screen && (in_row || in_col);
    endfunction

endpackage
`default_nettype wire

// File: rtl/explosion_channel.sv
`default_nettype none
// ------------------------------------------------------------------
// explosion_channel : one blast slot - lifetime FSM, centre, cross test
// Rev 1.0
// ------------------------------------------------------------------
module explosion_channel
    import explosion_pkg::*;
#(
    parameter int RADIUS      = 3,
    parameter int LIFE_CYCLES = 25_000_000,
    parameter int X_TILES     = DEF_X_TILES,
    parameter int Y_TILES     = DEF_Y_TILES
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       alloc_i,
    input  logic [9:0] cx_i,
    input  logic [9:0] cy_i,
    input  logic [9:0] pix_tx_i,
    input  logic [9:0] pix_ty_i,
    input  logic [9:0] ply_tx_i,
    input  logic [9:0] ply_ty_i,
    output logic       active_o,
    output logic       done_o,
    output logic       pix_hit_o,
    output logic       ply_hit_o
);

    localparam int            TW         = $clog2(LIFE_CYCLES);
    localparam logic [TW-1:0] TIMER_LOAD = TW'(LIFE_CYCLES - 1);

    ch_state_e     state_q;
    logic [TW-1:0] timer_q;
    logic [9:0]    cx_q;
    logic [9:0]    cy_q;
    logic          done_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= CH_IDLE;
            timer_q <= '0;
            cx_q    <= '0;
            cy_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                CH_IDLE: begin
                    if (alloc_i) begin
                        state_q <= CH_ACTIVE;
                        timer_q <= TIMER_LOAD;
                        cx_q    <= cx_i;
                        cy_q    <= cy_i;
                    end
                end
                CH_ACTIVE: begin
                    if (timer_q == '0) begin
                        state_q <= CH_IDLE;
                        done_q  <= 1'b1;
                    end else begin
                        timer_q <= timer_q - TW'(1);
                    end
                end
                default: state_q <= CH_IDLE;
            endcase
        end
    end

    assign active_o  = (state_q == CH_ACTIVE);
    assign done_o    = done_q;
    assign pix_hit_o = active_o &&
                       tile_in_cross(pix_tx_i, pix_ty_i, cx_q, cy_q, RADIUS, X_TILES, Y_TILES);
    assign ply_hit_o = active_o &&
                       tile_in_cross(ply_tx_i, ply_ty_i, cx_q, cy_q, RADIUS, X_TILES, Y_TILES);

endmodule
`default_nettype wire

// File: rtl/explosion_rom.sv
`default_nettype none
// ------------------------------------------------------------------
// explosion_rom : 16x16 flame sprite, 12-bit colour, registered read
// Rev 1.0
// ------------------------------------------------------------------
module explosion_rom (
    input  logic        clk,
    input  logic [3:0]  row_i,
    input  logic [3:0]  col_i,
    output logic [11:0] rgb_o
);

    // Procedurally generated palette: full red, green/blue textured by row/col.
    always_ff @(posedge clk) begin
        rgb_o <= {4'hF, row_i ^ col_i, row_i & col_i};
    end

endmodule
`default_nettype wire

// File: rtl/explosion_engine.sv
`default_nettype none
// ------------------------------------------------------------------
// explosion_engine : multi-channel cross-blast renderer and player hit
// Rev 1.0
// ------------------------------------------------------------------
module explosion_engine
    import explosion_pkg::*;
#(
    parameter int NUM_CH      = 2,
    parameter int RADIUS      = 3,
    parameter int TILE        = DEF_TILE,
    parameter int LIFE_CYCLES = 25_000_000,
    parameter int X_TILES     = DEF_X_TILES,
    parameter int Y_TILES     = DEF_Y_TILES
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              trig_valid_i,
    output logic              trig_ready_o,
    input  logic [9:0]        trig_x_i,
    input  logic [9:0]        trig_y_i,
    input  logic [9:0]        v_x_i,
    input  logic [9:0]        v_y_i,
    input  logic [9:0]        b_x_i,
    input  logic [9:0]        b_y_i,
    output logic              explosion_on_o,
    output logic [11:0]       rgb_out_o,
    output logic              player_hit_o,
    output logic [NUM_CH-1:0] active_mask_o,
    output logic [NUM_CH-1:0] done_o
);

    localparam int TS = $clog2(TILE);

    logic [NUM_CH-1:0] active;
    logic [NUM_CH-1:0] done_vec;
    logic [NUM_CH-1:0] pix_hit;
    logic [NUM_CH-1:0] ply_hit;
    logic [NUM_CH-1:0] alloc;
    logic              alloc_taken;

    logic [9:0]  trig_tx;
    logic [9:0]  trig_ty;
    logic [9:0]  pix_tx;
    logic [9:0]  pix_ty;
    logic [10:0] ply_cx;
    logic [10:0] ply_cy;
    logic [9:0]  ply_tx;
    logic [9:0]  ply_ty;

    logic        hit_d;
    logic [3:0]  row_d;
    logic [3:0]  col_d;
    logic        phit_d;
    logic        hit_q1;
    logic [3:0]  row_q1;
    logic [3:0]  col_q1;
    logic        hit_q2;
    logic        player_hit_q;
    logic [11:0] rom_rgb;

    assign trig_tx = trig_x_i >> TS;
    assign trig_ty = trig_y_i >> TS;
    assign pix_tx  = v_x_i >> TS;
    assign pix_ty  = v_y_i >> TS;

    // Centre point may run past 1023 near the right edge, hence the extra bit.
    assign ply_cx  = {1'b0, b_x_i} + 11'(TILE / 2);
    assign ply_cy  = {1'b0, b_y_i} + 11'(TILE / 2);
    assign ply_tx  = 10'(ply_cx >> TS);
    assign ply_ty  = 10'(ply_cy >> TS);

    assign trig_ready_o = ~&active;

    always_comb begin
        alloc       = '0;
        alloc_taken = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!alloc_taken && !active[i]) begin
                alloc[i]    = trig_valid_i;
                alloc_taken = 1'b1;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            explosion_channel #(
                .RADIUS      (RADIUS),
                .LIFE_CYCLES (LIFE_CYCLES),
                .X_TILES     (X_TILES),
                .Y_TILES     (Y_TILES)
            ) u_ch (
                .clk       (clk),
                .reset     (reset),
                .alloc_i   (alloc[gi]),
                .cx_i      (trig_tx),
                .cy_i      (trig_ty),
                .pix_tx_i  (pix_tx),
                .pix_ty_i  (pix_ty),
                .ply_tx_i  (ply_tx),
                .ply_ty_i  (ply_ty),
                .active_o  (active[gi]),
                .done_o    (done_vec[gi]),
                .pix_hit_o (pix_hit[gi]),
                .ply_hit_o (ply_hit[gi])
            );
        end
    endgenerate

    assign hit_d  = |pix_hit;
    assign phit_d = |ply_hit;
    assign col_d  = 4'(v_x_i & 10'(TILE - 1));
    assign row_d  = 4'(v_y_i & 10'(TILE - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hit_q1       <= 1'b0;
            row_q1       <= '0;
            col_q1       <= '0;
            hit_q2       <= 1'b0;
            player_hit_q <= 1'b0;
        end else begin
            hit_q1       <= hit_d;
            row_q1       <= row_d;
            col_q1       <= col_d;
            hit_q2       <= hit_q1;
            player_hit_q <= phit_d;
        end
    end

    explosion_rom u_rom (
        .clk   (clk),
        .row_i (row_q1),
        .col_i (col_q1),
        .rgb_o (rom_rgb)
    );

    // The ROM has no reset; gating by the delayed hit keeps rgb_out clean.
    assign rgb_out_o      = hit_q2 ? rom_rgb : 12'h000;
    assign explosion_on_o = hit_q2;
    assign player_hit_o   = player_hit_q;
    assign active_mask_o  = active;
    assign done_o         = done_vec;

endmodule
`default_nettype wire

// File: tb/tb_explosion_engine.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_explosion_engine : directed vectors plus randomized model check
// Rev 1.0
// ------------------------------------------------------------------
module tb_explosion_engine;

    localparam int NCH  = 2;
    localparam int RAD  = 3;
    localparam int TILE = 16;
    localparam int LIFE = 8;
    localparam int XT   = 40;
    localparam int YT   = 30;
    localparam int NR   = 1500;

    logic           clk = 1'b0;
    logic           reset;
    logic           trig_valid;
    logic           trig_ready;
    logic [9:0]     trig_x, trig_y, v_x, v_y, b_x, b_y;
    logic           explosion_on;
    logic [11:0]    rgb_out;
    logic           player_hit;
    logic [NCH-1:0] active_mask;
    logic [NCH-1:0] done;

    int checks = 0;
    int errors = 0;

    explosion_engine #(
        .NUM_CH      (NCH),
        .RADIUS      (RAD),
        .TILE        (TILE),
        .LIFE_CYCLES (LIFE),
        .X_TILES     (XT),
        .Y_TILES     (YT)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .trig_valid_i   (trig_valid),
        .trig_ready_o   (trig_ready),
        .trig_x_i       (trig_x),
        .trig_y_i       (trig_y),
        .v_x_i          (v_x),
        .v_y_i          (v_y),
        .b_x_i          (b_x),
        .b_y_i          (b_y),
        .explosion_on_o (explosion_on),
        .rgb_out_o      (rgb_out),
        .player_hit_o   (player_hit),
        .active_mask_o  (active_mask),
        .done_o         (done)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish (got timeout, required finish)");
        $fatal(1);
    end

    typedef struct {
        int          vx;
        int          vy;
        int          bx;
        int          by;
        bit          on;
        logic [11:0] rgb;
        bit          ph;
    } vec_t;

    // Reference model: each channel remembers the cycle its blast was accepted.
    int st[NCH];
    int done_at[NCH];
    int mcx[NCH];
    int mcy[NCH];
    bit          eph[NR+3];
    bit          eon[NR+3];
    logic [11:0] ergb[NR+3];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic bit m_act(int ch, int c);
        return (c >= st[ch] + 1) && (c <= st[ch] + LIFE);
    endfunction

    function automatic bit m_cross(int tx, int ty, int cx, int cy);
        int dx = tx - cx;
        int dy = ty - cy;
        if (tx >= XT || ty >= YT) return 1'b0;
        return (dy == 0 && dx * dx <= RAD * RAD) || (dx == 0 && dy * dy <= RAD * RAD);
    endfunction

    function automatic bit m_hit(int px, int py, int c);
        bit h = 1'b0;
        for (int ch = 0; ch < NCH; ch++)
            if (m_act(ch, c) && m_cross(px / TILE, py / TILE, mcx[ch], mcy[ch])) h = 1'b1;
        return h;
    endfunction

    function automatic logic [11:0] m_rom(int px, int py);
        int r = py % TILE;
        int c = px % TILE;
        return {4'hF, 4'(r ^ c), 4'(r & c)};
    endfunction

    initial begin
        vec_t           tbl[8];
        logic [NCH-1:0] exp_mask;
        logic [NCH-1:0] exp_done;
        int             px, py, bx, by, tx, ty, k;
        bit             tv;

        tbl[0] = '{48,  0,   312, 232, 1'b1, 12'hF00, 1'b1};
        tbl[1] = '{64,  0,   352, 272, 1'b0, 12'h000, 1'b0};
        tbl[2] = '{624, 0,   0,   0,   1'b0, 12'h000, 1'b1};
        tbl[3] = '{0,   464, 352, 272, 1'b0, 12'h000, 1'b0};
        tbl[4] = '{336, 240, 312, 232, 1'b1, 12'hF00, 1'b1};
        tbl[5] = '{336, 256, 352, 272, 1'b0, 12'h000, 1'b0};
        tbl[6] = '{53,  7,   600, 440, 1'b1, 12'hF25, 1'b0};
        tbl[7] = '{320, 288, 352, 272, 1'b1, 12'hF00, 1'b0};

        reset = 1'b1; trig_valid = 1'b0; trig_x = '0; trig_y = '0;
        v_x = 10'd1000; v_y = 10'd1000; b_x = 10'd1000; b_y = 10'd1000;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mask", 32'(active_mask), 32'd0);
        chk("rst_on", 32'(explosion_on), 32'd0);
        reset = 1'b0;
        step();
        chk("rel_ready", 32'(trig_ready), 32'd1);
        chk("rel_mask", 32'(active_mask), 32'd0);
        chk("rel_done", 32'(done), 32'd0);
        chk("rel_on", 32'(explosion_on), 32'd0);
        chk("rel_rgb", 32'(rgb_out), 32'd0);
        chk("rel_phit", 32'(player_hit), 32'd0);

        // Single blast lifetime
        trig_valid = 1'b1; trig_x = 10'd160; trig_y = 10'd160;
        chk("life_ready0", 32'(trig_ready), 32'd1);
        step();
        trig_valid = 1'b0;
        for (int i = 1; i <= LIFE; i++) begin
            chk("life_mask", 32'(active_mask), 32'd1);
            chk("life_ready", 32'(trig_ready), 32'd1);
            chk("life_nodone", 32'(done), 32'd0);
            step();
        end
        chk("life_end_mask", 32'(active_mask), 32'd0);
        chk("life_done", 32'(done), 32'd1);
        step();
        chk("life_done_clr", 32'(done), 32'd0);
        repeat (2) step();

        // Three back-to-back triggers with two channels
        trig_valid = 1'b1; trig_x = 10'd16; trig_y = 10'd32;
        chk("tri_ready0", 32'(trig_ready), 32'd1);
        step();
        chk("tri_mask1", 32'(active_mask), 32'd1);
        chk("tri_ready1", 32'(trig_ready), 32'd1);
        step();
        chk("tri_mask2", 32'(active_mask), 32'd3);
        chk("tri_ready2", 32'(trig_ready), 32'd0);
        step();
        trig_valid = 1'b0;
        chk("tri_mask3", 32'(active_mask), 32'd3);
        repeat (6) step();
        chk("tri_mask9", 32'(active_mask), 32'd2);
        chk("tri_done9", 32'(done), 32'd1);
        step();
        chk("tri_mask10", 32'(active_mask), 32'd0);
        chk("tri_done10", 32'(done), 32'd2);
        repeat (3) step();

        // Table: blasts at (0,0) in ch0 and (320,240) in ch1, pipelined pixel/player probes
        trig_valid = 1'b1; trig_x = 10'd0; trig_y = 10'd0;
        step();
        trig_x = 10'd320; trig_y = 10'd240;
        step();
        trig_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (i < 8) begin
                v_x = 10'(tbl[i].vx); v_y = 10'(tbl[i].vy);
                b_x = 10'(tbl[i].bx); b_y = 10'(tbl[i].by);
            end
            step();
            if (i < 8) chk($sformatf("tbl%0d_phit", i), 32'(player_hit), 32'(tbl[i].ph));
            if (i >= 1 && i <= 8) begin
                chk($sformatf("tbl%0d_on", i - 1), 32'(explosion_on), 32'(tbl[i-1].on));
                chk($sformatf("tbl%0d_rgb", i - 1), 32'(rgb_out), 32'(tbl[i-1].rgb));
            end
        end
        v_x = 10'd1000; v_y = 10'd1000; b_x = 10'd1000; b_y = 10'd1000;
        repeat (10) step();

        // Reset in the middle of a blast
        trig_valid = 1'b1; trig_x = 10'd320; trig_y = 10'd240;
        v_x = 10'd320; v_y = 10'd240; b_x = 10'd312; b_y = 10'd232;
        step();
        trig_valid = 1'b0;
        repeat (2) step();
        chk("mid_on_before", 32'(explosion_on), 32'd1);
        chk("mid_phit_before", 32'(player_hit), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_mask", 32'(active_mask), 32'd0);
        chk("mid_on", 32'(explosion_on), 32'd0);
        chk("mid_rgb", 32'(rgb_out), 32'd0);
        chk("mid_phit", 32'(player_hit), 32'd0);
        chk("mid_done", 32'(done), 32'd0);
        chk("mid_ready", 32'(trig_ready), 32'd1);
        repeat (2) step();
        reset = 1'b0;
        v_x = 10'd1000; v_y = 10'd1000; b_x = 10'd1000; b_y = 10'd1000;
        for (int i = 0; i < LIFE + 3; i++) begin
            step();
            chk("post_rst_done", 32'(done), 32'd0);
        end
        trig_valid = 1'b1; trig_x = 10'd100; trig_y = 10'd100;
        step();
        trig_valid = 1'b0;
        chk("post_rst_alloc", 32'(active_mask), 32'd1);
        repeat (12) step();

        // Randomized run against the reference model
        for (int ch = 0; ch < NCH; ch++) begin
            st[ch] = -100; done_at[ch] = -100; mcx[ch] = 0; mcy[ch] = 0;
        end
        for (int c = 0; c < NR; c++) begin
            exp_mask = '0;
            exp_done = '0;
            for (int ch = 0; ch < NCH; ch++) begin
                exp_mask[ch] = m_act(ch, c);
                exp_done[ch] = (c == done_at[ch]);
            end
            chk("rnd_mask", 32'(active_mask), 32'(exp_mask));
            chk("rnd_done", 32'(done), 32'(exp_done));
            chk("rnd_ready", 32'(trig_ready), 32'(~&exp_mask));
            if (c >= 1) chk("rnd_phit", 32'(player_hit), 32'(eph[c]));
            if (c >= 2) begin
                chk("rnd_on", 32'(explosion_on), 32'(eon[c]));
                chk("rnd_rgb", 32'(rgb_out), 32'(ergb[c]));
            end

            tv = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 3) == 0) begin
                tx = int'($urandom_range(0, 1023)); ty = int'($urandom_range(0, 1023));
            end else begin
                tx = int'($urandom_range(0, 639));  ty = int'($urandom_range(0, 479));
            end
            k = int'($urandom_range(0, NCH - 1));
            if ($urandom_range(0, 2) == 0) begin
                px = int'($urandom_range(0, 1023)); py = int'($urandom_range(0, 1023));
            end else begin
                px = (mcx[k] * TILE + int'($urandom_range(0, 160)) - 80) & 1023;
                py = (mcy[k] * TILE + int'($urandom_range(0, 160)) - 80) & 1023;
            end
            bx = (mcx[k] * TILE + int'($urandom_range(0, 160)) - 88) & 1023;
            by = (mcy[k] * TILE + int'($urandom_range(0, 160)) - 88) & 1023;

            trig_valid = tv; trig_x = 10'(tx); trig_y = 10'(ty);
            v_x = 10'(px); v_y = 10'(py); b_x = 10'(bx); b_y = 10'(by);

            eph[c+1]  = m_hit(bx + TILE / 2, by + TILE / 2, c);
            eon[c+2]  = m_hit(px, py, c);
            ergb[c+2] = eon[c+2] ? m_rom(px, py) : 12'h000;

            if (tv) begin
                for (int ch = 0; ch < NCH; ch++) begin
                    if (!exp_mask[ch]) begin
                        st[ch]      = c;
                        done_at[ch] = c + LIFE + 1;
                        mcx[ch]     = tx / TILE;
                        mcy[ch]     = ty / TILE;
                        break;
                    end
                end
            end
            step();
        end
        trig_valid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
